alu_bcd_display_seq: RTL and testbench

//  Registered, parametrised ALU-to-7-segment front end. On a start strobe it latches the

---
 rtl/alu_bcd_display_seq_if.sv | 30 +++
 rtl/alu_bcd_display_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_bcd_display_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bcd_display_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_bcd_display_seq_if : start/busy/done bus of the ALU-to-display   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface alu_bcd_display_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [4:0]            sel;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic [4:0]            flags;
    logic [DIGITS*8-1:0]   disp;

    modport master (
        output start, a, b, sel,
        input  busy, done, result, flags, disp
    );

    modport slave (
        input  start, a, b, sel,
        output busy, done, result, flags, disp
    );
endinterface
`default_nettype wire

// File: rtl/alu_bcd_display_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_bcd_display_seq : registered ALU with sequential double-dabble   |
// | binary-to-BCD conversion driving one 7-segment decoder per digit.    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+

module alu #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] A,
    input  wire logic [WIDTH-1:0] B,
    input  wire logic [4:0]       sel,
    output logic      [WIDTH-1:0] Q,
    output logic      [4:0]       F
);
    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_SUB = 5'd1;
    localparam logic [4:0] c_OP_AND = 5'd2;
    localparam logic [4:0] c_OP_OR  = 5'd3;
    localparam logic [4:0] c_OP_XOR = 5'd4;
    localparam logic [4:0] c_OP_NOT = 5'd5;
    localparam logic [4:0] c_OP_SHL = 5'd6;
    localparam logic [4:0] c_OP_SHR = 5'd7;

    logic [WIDTH:0] w_ext;
    logic           w_carry;
    logic           w_ovf;

    // F = {parity, overflow, negative, zero, carry}; subtract carry means no borrow
    always_comb begin
        w_ext   = '0;
        Q       = A;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (sel)
            c_OP_ADD: begin
                w_ext   = {1'b0, A} + {1'b0, B};
                Q       = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
                w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (Q[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_ext   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                Q       = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
                w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (Q[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_AND: Q = A & B;
            c_OP_OR:  Q = A | B;
            c_OP_XOR: Q = A ^ B;
            c_OP_NOT: Q = ~A;
            c_OP_SHL: begin
                Q       = A << 1;
                w_carry = A[WIDTH-1];
            end
            c_OP_SHR: begin
                Q       = A >> 1;
                w_carry = A[0];
            end
            default:  Q = A;
        endcase
        F = {^Q, w_ovf, Q[WIDTH-1], (Q == '0), w_carry};
    end
endmodule

module decoderBCD (
    input  wire logic [3:0] bcd,
    output logic      [7:0] seg
);
    // Active-low {dp,g,f,e,d,c,b,a}; non-decimal codes light nothing
    always_comb begin
        case (bcd)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    end
endmodule

module alu_bcd_display_seq #(
    parameter int         WIDTH      = 8,
    parameter int         DIGITS     = 3,
    parameter bit         BLANK_LZ   = 1'b0,
    parameter logic [7:0] BLANK_CODE = 8'hFF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_bcd_display_seq_if.slave bus
);
    localparam int c_SW = 4*DIGITS + WIDTH;
    localparam int c_CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_CONVERT = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    function automatic longint unsigned f_pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    generate
        if (f_pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
            $error("DIGITS too small to display every WIDTH-bit result");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      a_q, b_q;
    logic [4:0]            sel_q;
    logic [WIDTH-1:0]      result_q;
    logic [4:0]            flags_q;
    logic [c_SW-1:0]       shift_q;
    logic [c_CW-1:0]       cnt_q;
    logic [DIGITS*8-1:0]   disp_q;

    logic [WIDTH-1:0]      w_alu_q;
    logic [4:0]            w_alu_f;
    logic [c_SW-1:0]       w_shift_adj;
    logic [c_SW-1:0]       w_shift_next;
    logic                  w_last;
    logic [3:0]            w_nib [DIGITS];
    logic [7:0]            w_seg [DIGITS];
    logic [DIGITS*8-1:0]   w_disp;
    logic                  w_zero_run;

    alu #(.WIDTH(WIDTH)) u_alu (
        .A   (a_q),
        .B   (b_q),
        .sel (sel_q),
        .Q   (w_alu_q),
        .F   (w_alu_f)
    );

    always_comb begin
        w_shift_adj = shift_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (shift_q[WIDTH + 4*k +: 4] >= 4'd5)
                w_shift_adj[WIDTH + 4*k +: 4] = shift_q[WIDTH + 4*k +: 4] + 4'd3;
        end
        w_shift_next = w_shift_adj << 1;
    end

    assign w_last = (cnt_q == c_CW'(WIDTH - 1));

    // Decoders see the post-shift BCD so disp can be loaded on the last shift; reset shows zeros
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_nib[k] = rst ? 4'd0 : w_shift_next[WIDTH + 4*k +: 4];
            decoderBCD u_dec (.bcd(w_nib[k]), .seg(w_seg[k]));
        end
    endgenerate

    always_comb begin
        w_zero_run = 1'b1;
        w_disp     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (w_nib[k] == 4'd0);
            if (BLANK_LZ && (k > 0) && w_zero_run)
                w_disp[8*k +: 8] = BLANK_CODE;
            else
                w_disp[8*k +: 8] = w_seg[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:    if (bus.start) state_d = c_CAPTURE;
            c_CAPTURE: state_d = c_CONVERT;
            c_CONVERT: if (w_last) state_d = c_DONE;
            c_DONE:    state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            disp_q   <= w_disp;
        end else begin
            state_q <= state_d;
            case (state_q)
                c_IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sel_q <= bus.sel;
                    end
                end
                c_CAPTURE: begin
                    result_q <= w_alu_q;
                    flags_q  <= w_alu_f;
                    shift_q  <= {(4*DIGITS)'(0), w_alu_q};
                    cnt_q    <= '0;
                end
                c_CONVERT: begin
                    shift_q <= w_shift_next;
                    cnt_q   <= cnt_q + c_CW'(1);
                    if (w_last) disp_q <= w_disp;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != c_IDLE);
    assign bus.done   = (state_q == c_DONE);
    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.disp   = disp_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_bcd_display_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_bcd_display_seq : vector table plus scoreboard for two DUTs   |
// | (leading-zero blanking off and on).                                  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_alu_bcd_display_seq;
    localparam int         W      = 8;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;

    typedef struct {
        bit         dut;
        logic [7:0] a, b;
        logic [4:0] sel;
        logic [7:0] res;
        logic [4:0] flg;
        int         d2, d1, d0;
        logic [2:0] blank;
        int         intrude;
    } vec_t;

    typedef struct {
        logic [7:0]  res;
        logic [4:0]  flg;
        logic [23:0] disp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    sb_t  q0[$];
    sb_t  q1[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_bcd_display_seq_if #(.WIDTH(W), .DIGITS(3)) bus0();
    alu_bcd_display_seq_if #(.WIDTH(W), .DIGITS(3)) bus1();

    alu_bcd_display_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b0), .BLANK_CODE(8'hFF)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    alu_bcd_display_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b1), .BLANK_CODE(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [7:0] seg7(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [23:0] exp_disp(input vec_t v);
        return {v.blank[2] ? 8'hFF : seg7(v.d2),
                v.blank[1] ? 8'hFF : seg7(v.d1),
                v.blank[0] ? 8'hFF : seg7(v.d0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit d, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [4:0] sel);
        if (d == 1'b0) begin
            bus0.start = s; bus0.a = a; bus0.b = b; bus0.sel = sel;
        end else begin
            bus1.start = s; bus1.a = a; bus1.b = b; bus1.sel = sel;
        end
    endtask

    function automatic logic get_done(input bit d);
        return (d == 1'b0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic get_busy(input bit d);
        return (d == 1'b0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic sb_pop(input bit d, input logic [7:0] res, input logic [4:0] flg,
                          input logic [23:0] disp);
        sb_t e;
        if ((d == 1'b0 && q0.size() == 0) || (d == 1'b1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done dut%0d actual=1 required=0", d);
        end else begin
            e = (d == 1'b0) ? q0.pop_front() : q1.pop_front();
            chk(d ? "result1" : "result0", res, e.res);
            chk(d ? "flags1" : "flags0", flg, e.flg);
            chk(d ? "disp1" : "disp0", disp, e.disp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus0.done) sb_pop(1'b0, bus0.result, bus0.flags, bus0.disp);
        if (bus1.done) sb_pop(1'b1, bus1.result, bus1.flags, bus1.disp);
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy0"},   bus0.busy,   1'b0);
        chk({tag, "_done0"},   bus0.done,   1'b0);
        chk({tag, "_result0"}, bus0.result, 8'd0);
        chk({tag, "_flags0"},  bus0.flags,  5'd0);
        chk({tag, "_disp0"},   bus0.disp,   24'hC0C0C0);
        chk({tag, "_disp1"},   bus1.disp,   24'hFFFFC0);
    endtask

    task automatic run_op(input vec_t v);
        sb_t e;
        int  n;
        e.res = v.res; e.flg = v.flg; e.disp = exp_disp(v);
        if (v.dut == 1'b0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        set_in(v.dut, 1'b1, v.a, v.b, v.sel);
        @(posedge clk); #1;
        set_in(v.dut, 1'b0, v.a, v.b, v.sel);
        chk("busy_after_start", get_busy(v.dut), 1'b1);
        n = 1;
        while (!get_done(v.dut) && n < 40) begin
            if (v.intrude != 0 && n == v.intrude) set_in(v.dut, 1'b1, 8'd1, 8'd1, OP_ADD);
            if (v.intrude != 0 && n == v.intrude + 1) set_in(v.dut, 1'b0, 8'd1, 8'd1, OP_ADD);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W + 2);
        @(posedge clk); #1;
        chk("busy_after_done", get_busy(v.dut), 1'b0);
        chk("done_pulse_width", get_done(v.dut), 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t e;
        int  n, m;
        vecs[0]  = '{1'b0, 8'd200, 8'd55,  OP_ADD, 8'd255, 5'b00100, 2, 5, 5, 3'b000, 0};
        vecs[1]  = '{1'b0, 8'd9,   8'd3,   OP_ADD, 8'd12,  5'b00000, 0, 1, 2, 3'b000, 3};
        vecs[2]  = '{1'b0, 8'd200, 8'd100, OP_ADD, 8'd44,  5'b10001, 0, 4, 4, 3'b000, 0};
        vecs[3]  = '{1'b0, 8'd5,   8'd10,  OP_SUB, 8'd251, 5'b10100, 2, 5, 1, 3'b000, 0};
        vecs[4]  = '{1'b0, 8'd100, 8'd100, OP_SUB, 8'd0,   5'b00011, 0, 0, 0, 3'b000, 0};
        vecs[5]  = '{1'b0, 8'hF0,  8'h3C,  OP_AND, 8'd48,  5'b00000, 0, 4, 8, 3'b000, 0};
        vecs[6]  = '{1'b0, 8'hAA,  8'h0F,  OP_XOR, 8'd165, 5'b00100, 1, 6, 5, 3'b000, 0};
        vecs[7]  = '{1'b0, 8'd127, 8'd1,   OP_ADD, 8'd128, 5'b11100, 1, 2, 8, 3'b000, 0};
        vecs[8]  = '{1'b0, 8'd1,   8'd2,   OP_OR,  8'd3,   5'b00000, 0, 0, 3, 3'b000, 0};
        vecs[9]  = '{1'b1, 8'd3,   8'd4,   OP_ADD, 8'd7,   5'b10000, 0, 0, 7, 3'b110, 0};
        vecs[10] = '{1'b1, 8'd0,   8'd0,   OP_ADD, 8'd0,   5'b00010, 0, 0, 0, 3'b110, 0};
        vecs[11] = '{1'b1, 8'd50,  8'd55,  OP_ADD, 8'd105, 5'b00000, 1, 0, 5, 3'b000, 0};
        vecs[12] = '{1'b1, 8'd30,  8'd10,  OP_ADD, 8'd40,  5'b00000, 0, 4, 0, 3'b100, 0};

        set_in(1'b0, 1'b0, 8'd0, 8'd0, 5'd0);
        set_in(1'b1, 1'b0, 8'd0, 8'd0, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        chk("reset_busy1", bus1.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // Abort during the fourth conversion cycle: no done, reset values restored
        @(negedge clk);
        set_in(1'b0, 1'b1, 8'd1, 8'd1, OP_ADD);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 8'd1, 8'd1, OP_ADD);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("abort");
        repeat (W + 4) @(posedge clk);
        #1;
        chk("abort_queue_empty", q0.size(), 0);
        run_op('{1'b0, 8'd1, 8'd1, OP_ADD, 8'd2, 5'b10000, 0, 0, 2, 3'b000, 0});

        // Start held high across done: re-accepted only after returning to IDLE
        e.res = 8'd5; e.flg = 5'b00000; e.disp = {8'hC0, 8'hC0, 8'h92};
        q0.push_back(e);
        q0.push_back(e);
        @(negedge clk);
        set_in(1'b0, 1'b1, 8'd2, 8'd3, OP_ADD);
        @(posedge clk); #1;
        n = 1;
        while (!bus0.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_latency1", n, W + 2);
        @(posedge clk); #1;
        chk("held_idle_gap", bus0.busy, 1'b0);
        @(posedge clk); #1;
        chk("held_reaccept", bus0.busy, 1'b1);
        set_in(1'b0, 1'b0, 8'd2, 8'd3, OP_ADD);
        m = 2;
        while (!bus0.done && m < 40) begin
            @(posedge clk); #1;
            m++;
        end
        chk("held_done_gap", m, W + 3);
        repeat (W + 4) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
